// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants and coordinate types for the VGA
// controller and the pixel generators that consume its x/y coordinates.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_DIV      = 2;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [7:0]         colour_t;

  function automatic int h_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_if.sv
// Pixel-generator and DAC-side signals of the VGA controller; master is the
// controller, slave is the pixel generator / connector side.
interface vga_if;
  import vga_pkg::*;

  coord_t  x, y;
  colour_t r_in, g_in, b_in;
  colour_t r_out, g_out, b_out;
  logic    vga_clk, hsync_n, vsync_n, blank_n, sync_n, frame_start;

  modport master (
    output x, y, vga_clk, hsync_n, vsync_n, blank_n, sync_n,
           r_out, g_out, b_out, frame_start,
    input  r_in, g_in, b_in
  );

  modport slave (
    input  x, y, vga_clk, hsync_n, vsync_n, blank_n, sync_n,
           r_out, g_out, b_out, frame_start,
    output r_in, g_in, b_in
  );

endinterface

// File: rtl/vga_sync_counter.sv
// Clock divider plus horizontal/vertical raster counters; pix_en marks the
// last system clock of each pixel so everything downstream advances together.
module vga_sync_counter import vga_pkg::*; #(
  parameter int DIV     = VGA_DIV,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic   clk,
  input  logic   rst_n,
  output logic   pix_en,
  output logic   vga_clk,
  output logic   frame_wrap,
  output coord_t hcnt,
  output coord_t vcnt
);

  localparam int DW = $clog2(DIV);

  logic [DW-1:0] div_cnt;
  logic          h_last, v_last;

  assign pix_en     = (div_cnt == DW'(DIV - 1));
  assign vga_clk    = (div_cnt >= DW'(DIV / 2));
  assign h_last     = (hcnt == coord_t'(H_TOTAL - 1));
  assign v_last     = (vcnt == coord_t'(V_TOTAL - 1));
  assign frame_wrap = pix_en && h_last && v_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (pix_en)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  // Vertical counter only moves on the pixel that ends a line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_controller.sv
// VGA raster timing generator: counters in vga_sync_counter, and here the
// output register stage that keeps sync, blank and colour mutually aligned.
module vga_controller import vga_pkg::*; #(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int DIV      = VGA_DIV
) (
  input  logic clk,
  input  logic rst_n,
  vga_if.master vga
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  generate
    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX || DIV < 2) begin : g_bad_params
      $error("vga_controller: totals must fit 10-bit counters and DIV must be >= 2");
    end
  endgenerate

  coord_t  hcnt, vcnt;
  logic    pix_en, frame_wrap;
  logic    visible, hsync_act, vsync_act;
  logic    blank_q, hsync_q, vsync_q, frame_q;
  colour_t r_q, g_q, b_q;

  vga_sync_counter #(
    .DIV     (DIV),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .vga_clk    (vga.vga_clk),
    .frame_wrap (frame_wrap),
    .hcnt       (hcnt),
    .vcnt       (vcnt)
  );

  // Compared as int so a boundary equal to 1024 cannot wrap in 10 bits.
  always_comb begin
    visible   = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
    hsync_act = (int'(hcnt) >= H_ACTIVE + H_FP) &&
                (int'(hcnt) <  H_ACTIVE + H_FP + H_SYNC);
    vsync_act = (int'(vcnt) >= V_ACTIVE + V_FP) &&
                (int'(vcnt) <  V_ACTIVE + V_FP + V_SYNC);
  end

  // Captured from the pre-increment counters, so outputs trail x/y by one pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else if (pix_en) begin
      blank_q <= visible;
      hsync_q <= !hsync_act;
      vsync_q <= !vsync_act;
      r_q     <= visible ? vga.r_in : '0;
      g_q     <= visible ? vga.g_in : '0;
      b_q     <= visible ? vga.b_in : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_q <= 1'b0;
    else
      frame_q <= frame_wrap;
  end

  assign vga.x           = hcnt;
  assign vga.y           = vcnt;
  assign vga.blank_n     = blank_q;
  assign vga.hsync_n     = hsync_q;
  assign vga.vsync_n     = vsync_q;
  assign vga.sync_n      = 1'b0;
  assign vga.r_out       = r_q;
  assign vga.g_out       = g_q;
  assign vga.b_out       = b_q;
  assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_controller.sv
// Scoreboard bench for vga_controller: one default-timing instance and one
// tiny-raster instance, both checked every clock against a closed-form model.
module tb_vga_controller;
  import vga_pkg::*;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vga_clk;
    logic       hsync_n;
    logic       vsync_n;
    logic       blank_n;
    logic       sync_n;
    logic       frame_start;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } obs_t;

  typedef struct {
    int   dut;
    int   sel;
    int   k;
    obs_t exp;
  } sb_t;

  typedef struct {
    int   dut;
    int   k;
    int   sel;
    logic val;
  } dir_t;

  localparam int S_FULL  = -1;
  localparam int S_BLANK = 0;
  localparam int S_HSYNC = 1;
  localparam int S_VSYNC = 2;
  localparam int S_FS    = 3;
  localparam int S_VCLK  = 4;

  int hA[2] = '{640, 4};
  int hF[2] = '{16, 1};
  int hS[2] = '{96, 1};
  int hB[2] = '{48, 1};
  int vA[2] = '{480, 3};
  int vF[2] = '{10, 1};
  int vS[2] = '{2, 1};
  int vB[2] = '{33, 1};
  int dv[2] = '{2, 3};

  logic clk;
  logic rst0, rst1;
  int   kk[2];
  int   nChecks, nFails;
  sb_t  sbq[$];
  dir_t dirs[$];
  obs_t obs0, obs1;
  event checkNow;

  vga_if vif0 ();
  vga_if vif1 ();

  vga_controller u_dut0 (
    .clk   (clk),
    .rst_n (rst0),
    .vga   (vif0.master)
  );

  vga_controller #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .DIV      (3)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst1),
    .vga   (vif1.master)
  );

  // Pixel generators: constant colour on the default raster, coordinate-derived on the tiny one.
  assign vif0.r_in = 8'hAA;
  assign vif0.g_in = 8'h55;
  assign vif0.b_in = 8'hFF;
  assign vif1.r_in = {vif1.x[3:0], vif1.y[3:0]};
  assign vif1.g_in = vif1.x[7:0] ^ 8'h5A;
  assign vif1.b_in = vif1.y[7:0] + 8'd1;

  assign obs0 = '{x: vif0.x, y: vif0.y, vga_clk: vif0.vga_clk, hsync_n: vif0.hsync_n,
                  vsync_n: vif0.vsync_n, blank_n: vif0.blank_n, sync_n: vif0.sync_n,
                  frame_start: vif0.frame_start, r: vif0.r_out, g: vif0.g_out, b: vif0.b_out};
  assign obs1 = '{x: vif1.x, y: vif1.y, vga_clk: vif1.vga_clk, hsync_n: vif1.hsync_n,
                  vsync_n: vif1.vsync_n, blank_n: vif1.blank_n, sync_n: vif1.sync_n,
                  frame_start: vif1.frame_start, r: vif1.r_out, g: vif1.g_out, b: vif1.b_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void colourOf(int d, int h, int v, output logic [7:0] r,
                                   output logic [7:0] g, output logic [7:0] b);
    if (d == 0) begin
      r = 8'hAA; g = 8'h55; b = 8'hFF;
    end else begin
      r = {h[3:0], v[3:0]};
      g = h[7:0] ^ 8'h5A;
      b = v[7:0] + 8'd1;
    end
  endfunction

  // Expected outputs after k clock edges since reset release (k = 0 in reset).
  function automatic obs_t model(int d, int k);
    obs_t o;
    int   ht, vt, ft, n, idx, m, h, v;
    logic vis;
    ht = hA[d] + hF[d] + hS[d] + hB[d];
    vt = vA[d] + vF[d] + vS[d] + vB[d];
    ft = ht * vt;
    n  = k / dv[d];
    idx = n % ft;
    o = '0;
    o.x = 10'(idx % ht);
    o.y = 10'(idx / ht);
    o.vga_clk = ((k % dv[d]) >= (dv[d] / 2));
    o.sync_n = 1'b0;
    o.frame_start = (k > 0) && (k % dv[d] == 0) && (idx == 0);
    o.hsync_n = 1'b1;
    o.vsync_n = 1'b1;
    if (n > 0) begin
      m = (n - 1) % ft;
      h = m % ht;
      v = m / ht;
      vis = (h < hA[d]) && (v < vA[d]);
      o.blank_n = vis;
      o.hsync_n = !((h >= hA[d] + hF[d]) && (h < hA[d] + hF[d] + hS[d]));
      o.vsync_n = !((v >= vA[d] + vF[d]) && (v < vA[d] + vF[d] + vS[d]));
      if (vis) colourOf(d, h, v, o.r, o.g, o.b);
    end
    return o;
  endfunction

  function automatic logic pick(obs_t o, int sel);
    case (sel)
      S_BLANK: return o.blank_n;
      S_HSYNC: return o.hsync_n;
      S_VSYNC: return o.vsync_n;
      S_FS:    return o.frame_start;
      default: return o.vga_clk;
    endcase
  endfunction

  task automatic addDir(int d, int k, int sel, logic val);
    dir_t e;
    e.dut = d; e.k = k; e.sel = sel; e.val = val;
    dirs.push_back(e);
  endtask

  task automatic checkOutput(sb_t e);
    obs_t act;
    logic a, x;
    act = (e.dut == 0) ? obs0 : obs1;
    nChecks++;
    if (e.sel == S_FULL) begin
      if (act !== e.exp) begin
        nFails++;
        $display("[TB] FAIL raster dut%0d edge %0d: got %h expected %h", e.dut, e.k, act, e.exp);
      end
    end else begin
      a = pick(act, e.sel);
      x = pick(e.exp, e.sel);
      if (a !== x) begin
        nFails++;
        $display("[TB] FAIL directed dut%0d edge %0d sig%0d: got %b expected %b",
                 e.dut, e.k, e.sel, a, x);
      end
    end
  endtask

  // Asserts reset mid-cycle and checks the outputs cleared before any clock edge.
  task automatic applyStimulus(int d);
    sb_t e;
    #2;
    if (d == 0) rst0 = 1'b0; else rst1 = 1'b0;
    #1;
    e.dut = d; e.sel = S_FULL; e.k = 0; e.exp = model(d, 0);
    sbq.push_back(e);
    -> checkNow;
    repeat (2) @(negedge clk);
    #2;
    if (d == 0) rst0 = 1'b1; else rst1 = 1'b1;
  endtask

  task automatic waitEdge(int d, int target);
    int i;
    for (i = 0; i < 5000 && kk[d] != target; i++) @(negedge clk);
    if (kk[d] != target) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL wait dut%0d: reached edge %0d, wanted %0d", d, kk[d], target);
    end
  endtask

  // Driver: counts edges since release and queues the expected response.
  always @(posedge clk) begin
    sb_t e;
    obs_t ex;
    for (int d = 0; d < 2; d++) begin
      if (((d == 0) ? rst0 : rst1) == 1'b1) kk[d] = kk[d] + 1;
      else kk[d] = 0;
      ex = model(d, kk[d]);
      e.dut = d; e.sel = S_FULL; e.k = kk[d]; e.exp = ex;
      sbq.push_back(e);
      foreach (dirs[i]) begin
        if (dirs[i].dut == d && dirs[i].k == kk[d] && kk[d] > 0) begin
          e.sel = dirs[i].sel;
          e.exp = '0;
          case (dirs[i].sel)
            S_BLANK: e.exp.blank_n     = dirs[i].val;
            S_HSYNC: e.exp.hsync_n     = dirs[i].val;
            S_VSYNC: e.exp.vsync_n     = dirs[i].val;
            S_FS:    e.exp.frame_start = dirs[i].val;
            default: e.exp.vga_clk     = dirs[i].val;
          endcase
          sbq.push_back(e);
        end
      end
    end
  end

  // Monitor: drains the scoreboard on every falling edge or on demand.
  initial begin
    forever begin
      @(negedge clk or checkNow);
      while (sbq.size() != 0) checkOutput(sbq.pop_front());
    end
  end

  initial begin
    nChecks = 0;
    nFails  = 0;
    kk[0] = 0;
    kk[1] = 0;
    rst0 = 1'b0;
    rst1 = 1'b0;

    addDir(0, 1,    S_BLANK, 1'b0);
    addDir(0, 2,    S_BLANK, 1'b1);
    addDir(0, 1281, S_BLANK, 1'b1);
    addDir(0, 1282, S_BLANK, 1'b0);
    addDir(0, 1313, S_HSYNC, 1'b1);
    addDir(0, 1314, S_HSYNC, 1'b0);
    addDir(0, 1505, S_HSYNC, 1'b0);
    addDir(0, 1506, S_HSYNC, 1'b1);
    addDir(0, 1601, S_BLANK, 1'b0);
    addDir(0, 1602, S_BLANK, 1'b1);
    addDir(1, 1,    S_VCLK,  1'b1);
    addDir(1, 2,    S_VCLK,  1'b1);
    addDir(1, 3,    S_VCLK,  1'b0);
    addDir(1, 86,   S_VSYNC, 1'b1);
    addDir(1, 87,   S_VSYNC, 1'b0);
    addDir(1, 107,  S_VSYNC, 1'b0);
    addDir(1, 108,  S_VSYNC, 1'b1);
    addDir(1, 125,  S_FS,    1'b0);
    addDir(1, 126,  S_FS,    1'b1);
    addDir(1, 127,  S_FS,    1'b0);
    addDir(1, 252,  S_FS,    1'b1);
    addDir(1, 378,  S_FS,    1'b1);

    repeat (3) @(negedge clk);
    #2;
    rst0 = 1'b1;
    rst1 = 1'b1;

    waitEdge(1, 440);
    applyStimulus(1);

    waitEdge(0, 2200);
    applyStimulus(0);

    repeat (1700) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
